// File: rtl/sreg_pkg.sv
// Shared types and limits for the serial transmitter slice.
// Holds the tx FSM state enum, gap counter width and legal WIDTH/GAP range.
package sreg_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_GAP    = 2'd3
  } tx_state_t;

  localparam int GAP_CNT_W = 4;
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;
  localparam int GAP_MIN   = 0;
  localparam int GAP_MAX   = 15;

endpackage

// File: rtl/sreg_bit_cnt.sv
// Enable-gated up-counter with synchronous clear and terminal-count flag.
// Ports: clk, rst (async low), clr, inc -> cnt[CW-1:0], tc (cnt == TC).
module sreg_bit_cnt #(
  parameter int CW = 3,
  parameter int TC = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == CW'(TC));

endmodule

// File: rtl/sreg_ser_tx.sv
// MSB-first parallel-to-serial transmitter with frame/last flags and idle gap.
// Ports: clk, rst (async low), en, din/din_valid/din_ready, data_out, frame, last.
// Option: SREG_SER_TX_PARITY_EN appends an even-parity bit to each frame.
module sreg_ser_tx
  import sreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             data_out,
  output logic             frame,
  output logic             last
);

  localparam int BW = $clog2(WIDTH);
  localparam int GTC = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [BW-1:0] BC_PEN = BW'(WIDTH - 2);

  localparam tx_state_t AFTER_FRAME =
    (GAP > 0) ? S_GAP : S_IDLE;
`ifdef SREG_SER_TX_PARITY_EN
  localparam tx_state_t AFTER_SHIFT = S_PARITY;
`else
  localparam tx_state_t AFTER_SHIFT = AFTER_FRAME;
`endif

  tx_state_t state, state_d;
  logic [WIDTH-1:0] sr, sr_d;
  logic accept, upd;
  logic data_d, frame_d, last_d;
  logic [BW-1:0] bcnt;
  logic [GAP_CNT_W-1:0] gcnt;
  logic bc_tc, gc_tc;
  logic bc_clr, bc_inc, gc_clr, gc_inc;
`ifdef SREG_SER_TX_PARITY_EN
  logic par;
`endif

  assign din_ready = (state == S_IDLE);

  always_comb begin
    state_d = state;
    sr_d    = sr;
    accept  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (din_valid) begin
          accept  = 1'b1;
          sr_d    = din;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (en) begin
          sr_d = sr << 1;
          if (bc_tc) state_d = AFTER_SHIFT;
        end
      end
`ifdef SREG_SER_TX_PARITY_EN
      S_PARITY: begin
        if (en) state_d = AFTER_FRAME;
      end
`endif
      S_GAP: begin
        if (en && gc_tc) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they only
  // move on an accept or an enabled advance; en=0 freezes them.
  assign upd = accept | ((state != S_IDLE) & en);

  always_comb begin
    frame_d = (state_d == S_SHIFT);
    data_d  = frame_d & sr_d[WIDTH-1];
    last_d  = 1'b0;
`ifdef SREG_SER_TX_PARITY_EN
    if (state_d == S_PARITY) begin
      frame_d = 1'b1;
      data_d  = par;
      last_d  = 1'b1;
    end
`else
    last_d = (state_d == S_SHIFT) &&
             (state == S_SHIFT) &&
             (bcnt == BC_PEN);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      sr       <= '0;
      data_out <= 1'b0;
      frame    <= 1'b0;
      last     <= 1'b0;
    end else begin
      state <= state_d;
      sr    <= sr_d;
      if (upd) begin
        data_out <= data_d;
        frame    <= frame_d;
        last     <= last_d;
      end
    end
  end

`ifdef SREG_SER_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par <= 1'b0;
    end else if (accept) begin
      par <= ^din;
    end
  end
`endif

  // Counters saturate at terminal count; each is cleared on entry.
  assign bc_clr = accept;
  assign bc_inc = (state == S_SHIFT) & en & ~bc_tc;
  assign gc_clr = (state_d == S_GAP) & (state != S_GAP);
  assign gc_inc = (state == S_GAP) & en & ~gc_tc;

  sreg_bit_cnt #(
    .CW(BW),
    .TC(WIDTH - 1)
  ) u_bit_cnt (
    .clk(clk),
    .rst(rst),
    .clr(bc_clr),
    .inc(bc_inc),
    .cnt(bcnt),
    .tc (bc_tc)
  );

  sreg_bit_cnt #(
    .CW(GAP_CNT_W),
    .TC(GTC)
  ) u_gap_cnt (
    .clk(clk),
    .rst(rst),
    .clr(gc_clr),
    .inc(gc_inc),
    .cnt(gcnt),
    .tc (gc_tc)
  );

endmodule

// File: tb/tb_sreg_ser_tx.sv
// Scoreboard bench for sreg_ser_tx: two instances (GAP=1 and GAP=2).
// Driver pushes expected per-cycle bits; monitors pop while frame is high.
module tb_sreg_ser_tx;

`ifdef SREG_SER_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = 8 + PAR;
  localparam int GAP_A = 1;
  localparam int GAP_B = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b1;
  logic [7:0] din_a = '0, din_b = '0;
  logic valid_a = 1'b0, valid_b = 1'b0;
  logic ready_a, ready_b;
  logic dout_a, dout_b;
  logic frame_a, frame_b;
  logic last_a, last_b;

  int n_vec = 0;
  int n_bad = 0;
  bit pace = 1'b0;

  logic [1:0] qa[$];
  logic [1:0] qb[$];

  always #5 clk = ~clk;

  sreg_ser_tx #(.WIDTH(8), .GAP(GAP_A)) dut_a (
    .clk(clk), .rst(rst), .en(en),
    .din(din_a), .din_valid(valid_a),
    .din_ready(ready_a), .data_out(dout_a),
    .frame(frame_a), .last(last_a)
  );

  sreg_ser_tx #(.WIDTH(8), .GAP(GAP_B)) dut_b (
    .clk(clk), .rst(rst), .en(en),
    .din(din_b), .din_valid(valid_b),
    .din_ready(ready_b), .data_out(dout_b),
    .frame(frame_b), .last(last_b)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [1:0] e;
    if (rst) begin
      if (frame_a) begin
        if (qa.size() == 0) begin
          chk("a_extra_bit", 1, 0);
        end else begin
          e = qa.pop_front();
          chk("a_bit", {31'd0, dout_a}, {31'd0, e[1]});
          chk("a_last", {31'd0, last_a}, {31'd0, e[0]});
        end
      end else begin
        chk("a_idle_out", {30'd0, dout_a, last_a}, 0);
      end
      if (frame_b) begin
        if (qb.size() == 0) begin
          chk("b_extra_bit", 1, 0);
        end else begin
          e = qb.pop_front();
          chk("b_bit", {31'd0, dout_b}, {31'd0, e[1]});
          chk("b_last", {31'd0, last_b}, {31'd0, e[0]});
        end
      end else begin
        chk("b_idle_out", {30'd0, dout_b, last_b}, 0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    if (pace) en = ~en;
  endtask

  task automatic push(input bit sel, input logic [7:0] w,
                      input int hold);
    logic [1:0] e;
    for (int i = 7; i >= 0; i--) begin
      for (int h = 0; h < hold; h++) begin
        e = {w[i], (i == 0 && PAR == 0)};
        if (sel) qb.push_back(e);
        else qa.push_back(e);
      end
    end
    if (PAR != 0) begin
      for (int h = 0; h < hold; h++) begin
        e = {^w, 1'b1};
        if (sel) qb.push_back(e);
        else qa.push_back(e);
      end
    end
  endtask

  task automatic wait_rdy(input bit sel, output int n);
    n = 0;
    while (!(sel ? ready_b : ready_a) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("ready_timeout", 1, 0);
  endtask

  task automatic send(input bit sel, input logic [7:0] w);
    int n;
    int hold;
    int g;
    hold = pace ? 2 : 1;
    g = sel ? GAP_B : GAP_A;
    wait_rdy(sel, n);
    if (sel) begin din_b = w; valid_b = 1'b1; end
    else begin din_a = w; valid_a = 1'b1; end
    if (pace) en = 1'b1;
    push(sel, w, hold);
    tick();
    if (sel) begin valid_b = 1'b0; din_b = 8'($urandom); end
    else begin valid_a = 1'b0; din_a = 8'($urandom); end
    wait_rdy(sel, n);
    chk("frame_spacing", n + 1, hold * (FL + g) + 1);
  endtask

  initial begin
    int n;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      en = 1'($urandom);
      din_a = 8'($urandom);
      valid_a = 1'($urandom);
      #1;
      chk("rst_outs", {29'd0, dout_a, frame_a, last_a}, 0);
      chk("rst_ready", {31'd0, ready_a}, 1);
    end
    tick();
    valid_a = 1'b0;
    en = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_quiet", {30'd0, frame_a, ready_a}, 1);
    end

    send(1'b0, 8'hA5);

    pace = 1'b1;
    send(1'b0, 8'h3C);
    pace = 1'b0;
    en = 1'b1;

    send(1'b0, 8'h07);
    send(1'b0, 8'h03);

    wait_rdy(1'b0, n);
    din_a = 8'hFF;
    valid_a = 1'b1;
    push(1'b0, 8'hFF, 1);
    tick();
    valid_a = 1'b0;
    tick();
    tick();
    tick();
    #1;
    rst = 1'b0;
    qa.delete();
    #1;
    chk("abort_outs", {29'd0, dout_a, frame_a, last_a}, 0);
    chk("abort_ready", {31'd0, ready_a}, 1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("abort_idle", {30'd0, frame_a, ready_a}, 1);
    send(1'b0, 8'h81);

    wait_rdy(1'b1, n);
    din_b = 8'h55;
    valid_b = 1'b1;
    push(1'b1, 8'h55, 1);
    tick();
    din_b = 8'hAA;
    wait_rdy(1'b1, n);
    chk("b2b_spacing", n + 1, FL + GAP_B + 1);
    push(1'b1, 8'hAA, 1);
    tick();
    valid_b = 1'b0;
    wait_rdy(1'b1, n);
    chk("b2b_second", n + 1, FL + GAP_B + 1);

    for (int i = 0; i < 4; i++) tick();
    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
